timer_status: RTL and testbench
===============================

Name: timer_status

Overview:
- Status/interrupt stage that sits directly downstream of the 8-bit timer counter.
- Consumes the counter value, the one-cycle-delayed counter value, and the counter control bits.
- Detects overflow (0xFF to 0x00 while counting up) and underflow (0x00 to 0xFF while counting down).
- Holds sticky status flags (TSR) that the bus clears with write-1-to-clear. Applies the interrupt-enable mask (TIER) and drives one level interrupt to the system.

Parameters:
- CNT_W, 8, counter width; MAX = all ones.
- TSR_W, 3, status width; bit0 OVF, bit1 UDF, bit2 CMP (bit2 is optional, see below).

Ports:
- clk_in  in  1  timer clock.
- presetn  in  1  reset, asynchronous, active-low.
- cnt  in  CNT_W  current counter value.
- last_cnt  in  CNT_W  counter value registered one clk_in earlier.
- en  in  1  counter enable (TCR[4]), same cycle as the counter sees it.
- load  in  1  counter load strobe, same cycle as the counter sees it.
- ud  in  1  direction; 1 = down, 0 = up.
- tsr_wr  in  1  one-cycle bus write strobe to TSR.
- tsr_wdata  in  TSR_W  write data; 1 = clear that bit.
- tier  in  TSR_W  interrupt enable mask.
- cmp_val  in  CNT_W  compare value; present only with TMR_CMP_EN.
- tsr  out  TSR_W  sticky status flags.
- ovf_pulse  out  1  single-cycle overflow event.
- udf_pulse  out  1  single-cycle underflow event.
- tmr_int  out  1  level interrupt.

Behaviour:
- Reset values (async, presetn=0): tsr=0, ovf_pulse=0, udf_pulse=0, tmr_int=0, all internal qualifier flops=0.
- Qualifier stage:
  - en_q, load_q and ud_q register en, load and ud on every clk_in edge.
  - They therefore describe the step that produced the current cnt/last_cnt pair.
  - step_q = en_q & ~load_q.
- Overflow condition: step_q & ~ud_q & (last_cnt==MAX) & (cnt==0).
- Underflow condition: step_q & ud_q & (last_cnt==0) & (cnt==MAX).
- Loads never raise a flag. Example: a load of 0x00 over a count of 0xFF does not signal OVF.
- Latency:
  - Counter wraps at edge N, so the pair {last_cnt, cnt} is valid after edge N.
  - ovf_pulse/udf_pulse go high for exactly the cycle after edge N+1.
  - Matching tsr bit reads 1 from edge N+1.
- If the counter stalls (en=0) right after a wrap, no repeat pulse occurs, because last_cnt catches up at edge N+1.
- TSR update per bit, every edge:
  - next = (tsr & ~(tsr_wr ? tsr_wdata : 0)) | set.
  - Set has priority over a simultaneous clear.
  - Writing 0 has no effect.
  - Clear takes effect at the edge that samples tsr_wr.
- A repeated event while a bit is already set leaves it at 1 (no counting, no overrun).
- tmr_int: registered; tmr_int <= |(next_tsr & tier). It therefore asserts on the same edge as the tsr bit.
  - Changing tier masks or unmasks on the next edge.
  - Clearing the last enabled pending bit deasserts tmr_int on the clearing edge.
- Reset mid-operation: all flags and pulses drop immediately; the first post-reset step cannot flag (en_q=0).
- The block has no combinational path from inputs to outputs.

Optional Feature:
- Macro: TMR_CMP_EN.
- Defined:
  - cmp_val port exists.
  - cmp_set = step_q & (cnt==cmp_val) & (cnt!=last_cnt).
  - cmp_set drives tsr[2] with the same timing, W1C and priority rules as OVF. It has no pulse output.
- Not defined: cmp_val port absent, tsr[2] tied 0, tier[2] ignored.

Test Plan:
- Up count, en=1, ud=0, cnt 0xFD to 0xFF to 0x00 → ovf_pulse one cycle, one edge after the wrap; tsr=3'b001; with tier=3'b001, tmr_int=1 on the same edge.
- Down count, ud=1, cnt 0x01 to 0x00 to 0xFF, tier=0 → udf_pulse one cycle, tsr=3'b010, tmr_int stays 0; then tier=3'b010 → tmr_int=1 on the next edge.
- Counter at 0xFF, load=1 with reg_tdr=0x00 → cnt=0x00, last_cnt=0xFF but tsr stays 0, no pulse.
- tsr=3'b011, write tsr_wdata=3'b001 → tsr=3'b010; a write coinciding with a new overflow set edge → bit0 remains 1.
- presetn low while tsr=3'b011 and tmr_int=1 → all outputs 0 immediately; release, first wrap 0xFF to 0x00 after ≥2 enabled steps flags normally.
- With TMR_CMP_EN, cmp_val=0x10, up count 0x0E to 0x10 then en=0 for 5 cycles → tsr[2]=1 set once, no re-set while holding 0x10; without the macro → tsr[2]=0.

Source files
------------

// File: rtl/timer_status.sv
// timer_status: overflow/underflow (and optional compare) detection, sticky W1C status and masked interrupt
// Ports:
//   clk_in    - timer clock
//   presetn   - asynchronous active-low reset
//   cnt       - current counter value
//   last_cnt  - counter value registered one clk_in earlier
//   en        - counter enable, same cycle the counter sees it
//   load      - counter load strobe, same cycle the counter sees it
//   ud        - count direction, 1 = down
//   tsr_wr    - one-cycle bus write strobe to tsr
//   tsr_wdata - write-1-to-clear data for tsr
//   tier      - interrupt enable mask
//   cmp_val   - compare value (only with TMR_CMP_EN)
//   tsr       - sticky status: bit0 OVF, bit1 UDF, bit2 CMP
//   ovf_pulse - single-cycle overflow event
//   udf_pulse - single-cycle underflow event
//   tmr_int   - registered level interrupt
// Define TMR_CMP_EN to add the cmp_val port and the compare flag in tsr[2];
// otherwise tsr[2] is held at 0 and tier[2] has no effect.
module timer_status #(
   parameter int CNT_W = 8,
   parameter int TSR_W = 3
) (
   input  logic             clk_in,
   input  logic             presetn,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] last_cnt,
   input  logic             en,
   input  logic             load,
   input  logic             ud,
   input  logic             tsr_wr,
   input  logic [TSR_W-1:0] tsr_wdata,
   input  logic [TSR_W-1:0] tier,
`ifdef TMR_CMP_EN
   input  logic [CNT_W-1:0] cmp_val,
`endif
   output logic [TSR_W-1:0] tsr,
   output logic             ovf_pulse,
   output logic             udf_pulse,
   output logic             tmr_int
);
   localparam logic [CNT_W-1:0] MAX = '1;
`ifdef TMR_CMP_EN
   localparam logic [TSR_W-1:0] IMPL = 3'b111;
`else
   localparam logic [TSR_W-1:0] IMPL = 3'b011;
`endif
   logic en_q, load_q, ud_q, step_q;
   logic ovf_set, udf_set, cmp_set;
   logic [TSR_W-1:0] set, clr, next_tsr;
   // the registered controls describe the step that produced the current {last_cnt, cnt} pair
   always_ff @(posedge clk_in or negedge presetn) begin
      if (!presetn) begin
         en_q      <= 1'b0;
         load_q    <= 1'b0;
         ud_q      <= 1'b0;
         tsr       <= '0;
         ovf_pulse <= 1'b0;
         udf_pulse <= 1'b0;
         tmr_int   <= 1'b0;
      end else begin
         en_q      <= en;
         load_q    <= load;
         ud_q      <= ud;
         tsr       <= next_tsr;
         ovf_pulse <= ovf_set;
         udf_pulse <= udf_set;
         tmr_int   <= |(next_tsr & tier);
      end
   end
   // loads never flag, even when they jump across the wrap point
   assign step_q  = en_q & ~load_q;
   assign ovf_set = step_q & ~ud_q & (last_cnt == MAX) & (cnt == '0);
   assign udf_set = step_q & ud_q & (last_cnt == '0) & (cnt == MAX);
`ifdef TMR_CMP_EN
   assign cmp_set = step_q & (cnt == cmp_val) & (cnt != last_cnt);
`else
   assign cmp_set = 1'b0;
`endif
   // set wins over a simultaneous clear; unimplemented bits are forced to 0
   always_comb begin
      set      = '0;
      set[0]   = ovf_set;
      set[1]   = udf_set;
      set[2]   = cmp_set;
      clr      = tsr_wr ? tsr_wdata : '0;
      next_tsr = ((tsr & ~clr) | set) & IMPL;
   end
endmodule

// File: tb/tb_timer_status.sv
// tb_timer_status: directed plus randomized bench for timer_status against a counter-history reference model
// Ports: none (top-level bench); compile with TMR_CMP_EN to exercise the compare flag.
module tb_timer_status;
`ifdef TMR_CMP_EN
   localparam bit CMP_ON = 1'b1;
`else
   localparam bit CMP_ON = 1'b0;
`endif
   logic       clk_in = 1'b0;
   logic       presetn = 1'b0;
   logic [7:0] cnt = 8'hFD;
   logic [7:0] last_cnt = 8'hFD;
   logic [7:0] cmp_val = 8'h10;
   logic       en = 1'b0, load = 1'b0, ud = 1'b0, tsr_wr = 1'b0;
   logic [2:0] tsr_wdata = '0, tier = '0;
   logic [2:0] tsr;
   logic       ovf_pulse, udf_pulse, tmr_int;
   int         checks = 0, errors = 0;
   // model state: expected outputs and the events the previous counter step produced
   logic [2:0] exp_tsr = '0, pend = '0;
   logic       exp_ovf = 1'b0, exp_udf = 1'b0, exp_int = 1'b0;

   always #5 clk_in = ~clk_in;

   timer_status dut (
      .clk_in(clk_in), .presetn(presetn), .cnt(cnt), .last_cnt(last_cnt),
      .en(en), .load(load), .ud(ud), .tsr_wr(tsr_wr), .tsr_wdata(tsr_wdata), .tier(tier),
`ifdef TMR_CMP_EN
      .cmp_val(cmp_val),
`endif
      .tsr(tsr), .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse), .tmr_int(tmr_int)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_tsr"}, {5'd0, tsr}, {5'd0, exp_tsr});
      check({tag, "_ovf"}, {7'd0, ovf_pulse}, {7'd0, exp_ovf});
      check({tag, "_udf"}, {7'd0, udf_pulse}, {7'd0, exp_udf});
      check({tag, "_int"}, {7'd0, tmr_int}, {7'd0, exp_int});
   endtask

   // One clock of the upstream counter plus bus activity; the model flags an event one
   // edge after the counter step that wrapped (or hit the compare value).
   task automatic step(input string tag, input logic e, input logic l, input logic u,
                       input logic [7:0] tdr, input logic w, input logic [2:0] wd, input logic [2:0] ti);
      logic [7:0] nxt;
      logic [2:0] nxt_pend;
      en = e; load = l; ud = u; tsr_wr = w; tsr_wdata = wd; tier = ti;
      nxt = l ? tdr : e ? (u ? cnt - 8'd1 : cnt + 8'd1) : cnt;
      nxt_pend = '0;
      if (e && !l) begin
         nxt_pend[0] = !u && cnt == 8'hFF;
         nxt_pend[1] = u && cnt == 8'h00;
         nxt_pend[2] = CMP_ON && nxt == cmp_val;
      end
      @(posedge clk_in);
      exp_tsr = (exp_tsr & ~(w ? wd : 3'b000)) | pend;
      exp_ovf = pend[0];
      exp_udf = pend[1];
      exp_int = |(exp_tsr & ti);
      pend = nxt_pend;
      #1;
      last_cnt = cnt;
      cnt = nxt;
      tsr_wr = 1'b0;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      presetn = 1'b0;
      #1;
      exp_tsr = '0; pend = '0; exp_ovf = 1'b0; exp_udf = 1'b0; exp_int = 1'b0;
      check_all(tag);
      @(posedge clk_in);
      @(negedge clk_in);
      presetn = 1'b1;
   endtask

   initial begin
      logic [7:0] tdr;
      #12;
      check_all("reset");
      @(negedge clk_in);
      presetn = 1'b1;
      // up count FD -> FE -> FF -> 00, pulse one edge after the wrap
      step("up1", 1, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      step("up2", 1, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      step("wrap", 1, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      step("ovf", 0, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      check("ovf_pulse_hi", {7'd0, ovf_pulse}, 8'd1);
      check("ovf_tsr", {5'd0, tsr}, 8'h01);
      check("ovf_int", {7'd0, tmr_int}, 8'd1);
      step("stall", 0, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      check("ovf_pulse_lo", {7'd0, ovf_pulse}, 8'd0);
      step("clr0", 0, 0, 0, 8'h00, 1, 3'b001, 3'b001);
      // down count 01 -> 00 -> FF with interrupt masked, then unmask
      step("ld01", 0, 1, 1, 8'h01, 0, 3'b000, 3'b000);
      step("dn1", 1, 0, 1, 8'h00, 0, 3'b000, 3'b000);
      step("dn2", 1, 0, 1, 8'h00, 0, 3'b000, 3'b000);
      step("udf", 1, 0, 1, 8'h00, 0, 3'b000, 3'b000);
      check("udf_tsr", {5'd0, tsr}, 8'h02);
      check("udf_int_masked", {7'd0, tmr_int}, 8'd0);
      step("unmask", 0, 0, 1, 8'h00, 0, 3'b000, 3'b010);
      check("udf_int_unmasked", {7'd0, tmr_int}, 8'd1);
      // load of 00 over FF never flags
      step("ldFF", 0, 1, 0, 8'hFF, 0, 3'b000, 3'b011);
      step("ld00", 0, 1, 0, 8'h00, 0, 3'b000, 3'b011);
      step("ld_after", 0, 0, 0, 8'h00, 0, 3'b000, 3'b011);
      check("ld_no_ovf", {5'd0, tsr}, 8'h02);
      // build tsr=011, clear bit0, then clear coinciding with a new overflow
      step("ldFE", 0, 1, 0, 8'hFE, 0, 3'b000, 3'b011);
      step("c1", 1, 0, 0, 8'h00, 0, 3'b000, 3'b011);
      step("c2", 1, 0, 0, 8'h00, 0, 3'b000, 3'b011);
      step("set011", 0, 0, 0, 8'h00, 0, 3'b000, 3'b011);
      check("tsr011", {5'd0, tsr}, 8'h03);
      step("w1c", 0, 0, 0, 8'h00, 1, 3'b001, 3'b011);
      check("w1c_tsr", {5'd0, tsr}, 8'h02);
      step("ldFE2", 0, 1, 0, 8'hFE, 0, 3'b000, 3'b011);
      step("d1", 1, 0, 0, 8'h00, 0, 3'b000, 3'b011);
      step("d2", 1, 0, 0, 8'h00, 0, 3'b000, 3'b011);
      step("set_vs_clr", 0, 0, 0, 8'h00, 1, 3'b001, 3'b011);
      check("set_wins", {5'd0, tsr}, 8'h03);
      // async reset with flags and interrupt pending
      do_reset("midrst");
      step("r_ldFE", 0, 1, 0, 8'hFE, 0, 3'b000, 3'b001);
      step("r1", 1, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      step("r2", 1, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      step("r_ovf", 0, 0, 0, 8'h00, 0, 3'b000, 3'b001);
      check("post_rst_ovf", {5'd0, tsr}, 8'h01);
      step("r_clr", 0, 0, 0, 8'h00, 1, 3'b111, 3'b111);
      // compare 0E -> 0F -> 10, then hold for 5 cycles
      step("ld0E", 0, 1, 0, 8'h0E, 0, 3'b000, 3'b100);
      step("k1", 1, 0, 0, 8'h00, 0, 3'b000, 3'b100);
      step("k2", 1, 0, 0, 8'h00, 0, 3'b000, 3'b100);
      for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, 8'h00, 0, 3'b000, 3'b100);
      check("cmp_bit", {7'd0, tsr[2]}, {7'd0, CMP_ON});
      step("k_clr", 0, 0, 0, 8'h00, 1, 3'b100, 3'b100);
      step("k_held", 0, 0, 0, 8'h00, 0, 3'b000, 3'b100);
      check("cmp_no_reset", {7'd0, tsr[2]}, 8'd0);
      // randomized traffic biased toward the wrap points
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: tdr = 8'h00;
            1: tdr = 8'hFF;
            2: tdr = 8'hFE;
            3: tdr = 8'h01;
            4: tdr = cmp_val - 8'd1;
            default: tdr = 8'($urandom);
         endcase
         if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
         step("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 15) < 8 ? ud : ~ud, tdr,
              $urandom_range(0, 3) == 0, 3'($urandom), 3'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
